// File: rtl/fifo_wr_arb_if.sv
// Write-side bundle of the two-requester async FIFO write arbiter.
// The wafull signal exists only when FIFO_WR_ARB_AFULL_EN is defined.
interface fifo_wr_arb_if #(
  parameter int unsigned ADDRSIZE = 4,
  parameter int unsigned DATASIZE = 8
);
  logic                req0_valid;
  logic                req1_valid;
  logic [DATASIZE-1:0] req0_data;
  logic [DATASIZE-1:0] req1_data;
  logic                req0_last;
  logic                req1_last;
  logic                req0_ready;
  logic                req1_ready;
  logic [ADDRSIZE:0]   wq2_rptr;
  logic [ADDRSIZE:0]   wptr;
  logic [ADDRSIZE-1:0] waddr;
  logic [DATASIZE-1:0] wdata;
  logic                wclken;
  logic                wfull;
  logic [1:0]          grant;
`ifdef FIFO_WR_ARB_AFULL_EN
  logic                wafull;
`endif

  // Requesters plus the read-pointer synchronizer side
  modport master (
    output req0_valid, req1_valid, req0_data, req1_data, req0_last, req1_last, wq2_rptr,
`ifdef FIFO_WR_ARB_AFULL_EN
    input  wafull,
`endif
    input  req0_ready, req1_ready, wptr, waddr, wdata, wclken, wfull, grant
  );

  // Arbiter side
  modport slave (
    input  req0_valid, req1_valid, req0_data, req1_data, req0_last, req1_last, wq2_rptr,
`ifdef FIFO_WR_ARB_AFULL_EN
    output wafull,
`endif
    output req0_ready, req1_ready, wptr, waddr, wdata, wclken, wfull, grant
  );
endinterface

// File: rtl/fifo_wr_arb.sv
// Async FIFO write-domain pointer logic shared by two packet requesters.
// Round-robin arbitration between packets; a granted packet holds the write port
// until its last word. Optional almost-full flag: define FIFO_WR_ARB_AFULL_EN.
// The bus interface instance must use the same ADDRSIZE/DATASIZE as this module.
module fifo_wr_arb #(
  parameter int unsigned ADDRSIZE     = 4,
  parameter int unsigned DATASIZE     = 8,
  parameter int unsigned AFULL_MARGIN = 2
) (
  input logic          wclk,
  input logic          wrst_n,
  fifo_wr_arb_if.slave bus
);
  typedef enum logic [1:0] {StArb, StLock0, StLock1} state_e;

  state_e            state;
  logic              rr;          // requester that last finished a packet; the other goes first
  logic [ADDRSIZE:0] wbin;
  logic [ADDRSIZE:0] wbin_next;
  logic [ADDRSIZE:0] wgray_next;
  logic [ADDRSIZE:0] wptr;
  logic              wfull;
  logic              wfull_next;
  logic [1:0]        grant;
  logic              xfer0;
  logic              xfer1;
  logic              wclken;

  // Grant owner: locked requester, else round-robin among valid requesters
  always_comb begin
    grant = 2'b00;
    case (state)
      StLock0: grant = 2'b01;
      StLock1: grant = 2'b10;
      default: begin
        if (bus.req0_valid && (!bus.req1_valid || rr)) grant = 2'b01;
        else if (bus.req1_valid)                       grant = 2'b10;
      end
    endcase
    // Outputs go quiet as soon as reset asserts, not at the next edge
    if (!wrst_n) grant = 2'b00;
  end

  // Handshake, write strobe and next-pointer computation
  always_comb begin
    xfer0      = bus.req0_valid & grant[0] & ~wfull;
    xfer1      = bus.req1_valid & grant[1] & ~wfull;
    wclken     = xfer0 | xfer1;
    wbin_next  = wbin + {{ADDRSIZE{1'b0}}, wclken};
    wgray_next = (wbin_next >> 1) ^ wbin_next;
    // Full when the write pointer is one lap ahead of the read pointer
    wfull_next = (wgray_next == {~bus.wq2_rptr[ADDRSIZE:ADDRSIZE-1],
                                 bus.wq2_rptr[ADDRSIZE-2:0]});
  end

  assign bus.grant      = grant;
  assign bus.req0_ready = grant[0] & ~wfull;
  assign bus.req1_ready = grant[1] & ~wfull;
  assign bus.wclken     = wclken;
  assign bus.wdata      = grant[1] ? bus.req1_data : bus.req0_data;
  assign bus.waddr      = wbin[ADDRSIZE-1:0];
  assign bus.wptr       = wptr;
  assign bus.wfull      = wfull;

  // Binary/Gray write pointers and registered full flag
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin  <= '0;
      wptr  <= '0;
      wfull <= 1'b0;
    end else begin
      wbin  <= wbin_next;
      wptr  <= wgray_next;
      wfull <= wfull_next;
    end
  end

  // Packet lock FSM and round-robin pointer
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state <= StArb;
      rr    <= 1'b1;
    end else begin
      case (state)
        StArb: begin
          if (xfer0) begin
            if (bus.req0_last) rr    <= 1'b0;
            else               state <= StLock0;
          end else if (xfer1) begin
            if (bus.req1_last) rr    <= 1'b1;
            else               state <= StLock1;
          end
        end
        StLock0: begin
          if (xfer0 && bus.req0_last) begin
            state <= StArb;
            rr    <= 1'b0;
          end
        end
        StLock1: begin
          if (xfer1 && bus.req1_last) begin
            state <= StArb;
            rr    <= 1'b1;
          end
        end
        default: state <= StArb;
      endcase
    end
  end

`ifdef FIFO_WR_ARB_AFULL_EN
  localparam int unsigned AfullLevel = (2 ** ADDRSIZE) - AFULL_MARGIN;

  logic [ADDRSIZE:0] rbin;
  logic [ADDRSIZE:0] used_next;
  logic              wafull;

  // Gray-to-binary of the synchronized read pointer and occupancy after this cycle
  always_comb begin
    rbin = '0;
    for (int i = 0; i <= int'(ADDRSIZE); i++) begin
      rbin[i] = ^(bus.wq2_rptr >> i);
    end
    used_next = wbin_next - rbin;
  end

  // Registered almost-full flag
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) wafull <= 1'b0;
    else         wafull <= (32'(used_next) >= AfullLevel);
  end

  assign bus.wafull = wafull;
`endif
endmodule

// File: tb/tb_fifo_wr_arb.sv
// Self-checking bench for fifo_wr_arb: directed stimulus pushes expected writes
// into a scoreboard; a negedge monitor pops and compares each write it sees.
module tb_fifo_wr_arb;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;

  typedef struct {
    logic [1:0]  g;
    logic [3:0]  addr;
    logic [7:0]  data;
    logic [4:0]  wptr;
  } exp_t;

  logic wclk = 1'b0;
  logic wrst_n;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  fifo_wr_arb_if #(.ADDRSIZE(AW), .DATASIZE(DW)) bus ();

  fifo_wr_arb #(.ADDRSIZE(AW), .DATASIZE(DW), .AFULL_MARGIN(2)) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .bus    (bus)
  );

  always #5 wclk = ~wclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] gray(input logic [4:0] b);
    return (b >> 1) ^ b;
  endfunction

  task automatic push(input logic [1:0] g, input logic [3:0] a, input logic [7:0] d,
                      input logic [4:0] p);
    exp_t e;
    e.g = g; e.addr = a; e.data = d; e.wptr = p;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  task automatic idle();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_last  = 1'b0; bus.req1_last  = 1'b0;
    bus.req0_data  = '0;   bus.req1_data  = '0;
  endtask

  task automatic do_reset();
    idle();
    step(); step();
    wrst_n = 1'b0;
    bus.wq2_rptr = '0;
    step(); step();
    chk("wptr in reset", 32'(bus.wptr), 0);
    chk("wfull in reset", 32'(bus.wfull), 0);
`ifdef FIFO_WR_ARB_AFULL_EN
    chk("wafull in reset", 32'(bus.wafull), 0);
`endif
    wrst_n = 1'b1;
  endtask

  // Monitor: compare every write strobe against the scoreboard head
  exp_t       cur;
  logic       wptr_pend = 1'b0;
  logic [4:0] wptr_exp;
  always @(negedge wclk) begin
    if (wptr_pend) begin
      chk("wptr after write", 32'(bus.wptr), 32'(wptr_exp));
      wptr_pend = 1'b0;
    end
    if (bus.wclken === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected write: waddr 0x%0h wdata 0x%0h, expected no write",
                 bus.waddr, bus.wdata);
      end else begin
        cur = sb.pop_front();
        chk("write grant", 32'(bus.grant), 32'(cur.g));
        chk("write waddr", 32'(bus.waddr), 32'(cur.addr));
        chk("write wdata", 32'(bus.wdata), 32'(cur.data));
        wptr_exp  = cur.wptr;
        wptr_pend = 1'b1;
      end
    end
  end

  initial begin
    // Outputs held quiet during reset even with requests pending
    wrst_n = 1'b0;
    idle();
    bus.wq2_rptr   = '0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #12;
    chk("reset ready0", 32'(bus.req0_ready), 0);
    chk("reset ready1", 32'(bus.req1_ready), 0);
    chk("reset wclken", 32'(bus.wclken), 0);
    chk("reset grant", 32'(bus.grant), 0);
    chk("reset wptr", 32'(bus.wptr), 0);
    chk("reset wfull", 32'(bus.wfull), 0);
    idle();
    step();
    wrst_n = 1'b1;

    // Single word from requester 0
    push(2'b01, 4'd0, 8'hA5, 5'b00001);
    bus.req0_valid = 1'b1; bus.req0_last = 1'b1; bus.req0_data = 8'hA5;
    step();
    idle();
    step(); step();

    // Both valid, single-word packets alternate 0,1,0,1
    do_reset();
    push(2'b01, 4'd0, 8'h10, 5'b00001);
    push(2'b10, 4'd1, 8'h21, 5'b00011);
    push(2'b01, 4'd2, 8'h12, 5'b00010);
    push(2'b10, 4'd3, 8'h23, 5'b00110);
    for (int i = 0; i < 4; i++) begin
      bus.req0_valid = 1'b1; bus.req0_last = 1'b1; bus.req0_data = 8'(8'h10 + i);
      bus.req1_valid = 1'b1; bus.req1_last = 1'b1; bus.req1_data = 8'(8'h20 + i);
      step();
    end
    idle();
    step(); step();

    // Three-word packet from requester 0 keeps the port despite requester 1
    do_reset();
    push(2'b01, 4'd0, 8'h31, 5'b00001);
    push(2'b01, 4'd1, 8'h32, 5'b00011);
    push(2'b01, 4'd2, 8'h33, 5'b00010);
    push(2'b10, 4'd3, 8'h77, 5'b00110);
    bus.req1_valid = 1'b1; bus.req1_last = 1'b1; bus.req1_data = 8'h77;
    for (int i = 0; i < 3; i++) begin
      bus.req0_valid = 1'b1; bus.req0_last = (i == 2); bus.req0_data = 8'(8'h31 + i);
      if (i == 1) begin
        @(negedge wclk);
        chk("locked ready1", 32'(bus.req1_ready), 0);
      end
      step();
    end
    bus.req0_valid = 1'b0;
    step();
    idle();
    step(); step();

    // Fill to full, stall, then resume after the read pointer advances
    do_reset();
    for (int i = 0; i < 16; i++) begin
      push(2'b01, 4'(i), 8'(i), gray(5'(i + 1)));
      bus.req0_valid = 1'b1; bus.req0_last = 1'b1; bus.req0_data = 8'(i);
      step();
    end
    bus.req0_data = 8'hEE;
    @(negedge wclk);
    chk("full wfull", 32'(bus.wfull), 1);
    chk("full ready0", 32'(bus.req0_ready), 0);
    chk("full wclken", 32'(bus.wclken), 0);
    step();
    @(negedge wclk);
    chk("full stall wclken", 32'(bus.wclken), 0);
    step();
    bus.wq2_rptr = 5'b00001;
    push(2'b01, 4'd0, 8'hEE, 5'b11001);
    @(negedge wclk);
    chk("wfull before edge", 32'(bus.wfull), 1);
    step();
    @(negedge wclk);
    chk("wfull released", 32'(bus.wfull), 0);
    chk("ready0 released", 32'(bus.req0_ready), 1);
    step();
    idle();
    step(); step();

    // Reset while requester 1 holds the lock
    do_reset();
    push(2'b10, 4'd0, 8'h51, 5'b00001);
    bus.req1_valid = 1'b1; bus.req1_last = 1'b0; bus.req1_data = 8'h51;
    step();
    bus.req1_valid = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_last = 1'b1; bus.req0_data = 8'h61;
    @(negedge wclk);
    chk("lock1 grant", 32'(bus.grant), 2);
    chk("lock1 ready0", 32'(bus.req0_ready), 0);
    chk("lock1 ready1", 32'(bus.req1_ready), 1);
    @(posedge wclk);
    #2;
    bus.req1_valid = 1'b1; bus.req1_last = 1'b1; bus.req1_data = 8'h62;
    wrst_n = 1'b0;
    #1;
    chk("midpkt reset ready0", 32'(bus.req0_ready), 0);
    chk("midpkt reset ready1", 32'(bus.req1_ready), 0);
    chk("midpkt reset wclken", 32'(bus.wclken), 0);
    chk("midpkt reset grant", 32'(bus.grant), 0);
    chk("midpkt reset wptr", 32'(bus.wptr), 0);
    step();
    push(2'b01, 4'd0, 8'h61, 5'b00001);
    wrst_n = 1'b1;
    step();
    idle();
    step(); step();

`ifdef FIFO_WR_ARB_AFULL_EN
    // Almost-full asserts once 14 of 16 entries are used
    do_reset();
    for (int i = 0; i < 14; i++) begin
      push(2'b01, 4'(i), 8'(8'h80 + i), gray(5'(i + 1)));
      bus.req0_valid = 1'b1; bus.req0_last = 1'b1; bus.req0_data = 8'(8'h80 + i);
      step();
      if (i == 12) chk("wafull after 13", 32'(bus.wafull), 0);
      if (i == 13) chk("wafull after 14", 32'(bus.wafull), 1);
    end
    idle();
    step(); step();
    do_reset();
`endif

    step(); step();
    chk("scoreboard drained", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
